// File: rtl/fp_to_linear.sv
// Serial decoder from the 8-bit {S, E[2:0], F[3:0]} float code to a 12-bit two's-complement sample.
// Define FP_DECODE_BARREL_EN for a single-cycle barrel shift instead of the iterative E-step shifter.
module fp_to_linear #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_fp,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [11:0]      out_d,
  output logic             busy,
  output logic [CNT_W-1:0] dec_count,
  output logic [1:0]       dbg_state_o
);

  // Handshake: a transfer happens on any rising edge where valid and ready are both high;
  // in_ready is high only in IDLE, out_valid only in OUT, and out_d is stable while out_valid is high.

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic              sign_q, sign_d;
  logic [10:0]       mag_q, mag_d;
  logic [2:0]        exp_q, exp_d;
  logic [11:0]       out_d_q, out_d_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              shift_done;
  logic [10:0]       mag_final;

  // In the iterative build exp_q is the remaining shift count; in the barrel build it is E itself.
`ifdef FP_DECODE_BARREL_EN
  assign shift_done = 1'b1;
  assign mag_final  = mag_q << exp_q;
`else
  assign shift_done = (exp_q == 3'd0);
  assign mag_final  = mag_q;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (in_valid)   state_d = ST_SHIFT;
      ST_SHIFT: if (shift_done) state_d = ST_OUT;
      ST_OUT:   if (out_ready)  state_d = ST_IDLE;
      default:                  state_d = ST_IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state_q == ST_IDLE);
    out_valid = (state_q == ST_OUT);
    busy      = (state_q == ST_SHIFT) || (state_q == ST_OUT);
  end

  // Datapath next-state
  always_comb begin
    sign_d  = sign_q;
    mag_d   = mag_q;
    exp_d   = exp_q;
    out_d_d = out_d_q;
    count_d = count_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sign_d = in_fp[7];
          mag_d  = {7'd0, in_fp[3:0]};
          exp_d  = in_fp[6:4];
        end
      end
      ST_SHIFT: begin
        if (shift_done) begin
          // Negative zero falls out as +0 because -0 is 0 in two's complement.
          out_d_d = sign_q ? (~{1'b0, mag_final} + 12'd1) : {1'b0, mag_final};
        end else begin
          mag_d = mag_q << 1;
          exp_d = exp_q - 3'd1;
        end
      end
      ST_OUT: begin
        if (out_ready) count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sign_q  <= 1'b0;
      mag_q   <= 11'd0;
      exp_q   <= 3'd0;
      out_d_q <= 12'd0;
      count_q <= '0;
    end else begin
      sign_q  <= sign_d;
      mag_q   <= mag_d;
      exp_q   <= exp_d;
      out_d_q <= out_d_d;
      count_q <= count_d;
    end
  end

  assign out_d       = out_d_q;
  assign dec_count   = count_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_fp_to_linear.sv
// Directed bench for fp_to_linear: hand-computed decodes, stall, reset abort and counter wrap.
module tb_fp_to_linear;

  localparam int CNT_W = 4;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [7:0]       in_fp;
  logic             out_valid;
  logic             out_ready;
  logic [11:0]      out_d;
  logic             busy;
  logic [CNT_W-1:0] dec_count;
  logic [1:0]       dbg_state;

  int               n_vec;
  int               n_miscompare;
  logic [CNT_W-1:0] exp_count;
  logic [11:0]      exp_q[$];

  fp_to_linear #(.CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_fp       (in_fp),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_d       (out_d),
    .busy        (busy),
    .dec_count   (dec_count),
    .dbg_state_o (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miscompare++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int lat_of(input logic [7:0] code);
`ifdef FP_DECODE_BARREL_EN
    return 1;
`else
    return int'(code[6:4]) + 1;
`endif
  endfunction

  // Offer a code, wait for the result, check it, then complete the output handshake.
  task automatic do_code(input logic [7:0] code, input logic [11:0] exp_d, input bit early_ready);
    int lat;
    logic [11:0] want;
    check("in_ready_before", in_ready, 1);
    in_valid  = 1'b1;
    in_fp     = code;
    out_ready = early_ready;
    exp_q.push_back(exp_d);
    tick();
    in_valid = 1'b0;
    in_fp    = 8'h00;
    check("busy_after_accept", busy, 1);
    lat = 0;
    while (!out_valid && lat < 20) begin
      tick();
      lat++;
    end
    check("latency", lat, lat_of(code));
    want = exp_q.pop_front();
    check("out_d", out_d, want);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check("out_valid_released", out_valid, 0);
    check("in_ready_after_release", in_ready, 1);
    check("dec_count", dec_count, exp_count);
  endtask

  initial begin
    n_vec        = 0;
    n_miscompare = 0;
    exp_count    = '0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_fp     = 8'h00;
    out_ready = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    check("rst_state", dbg_state, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_d", out_d, 0);
    check("rst_busy", busy, 0);
    check("rst_dec_count", dec_count, 0);
    check("rst_in_ready", in_ready, 1);

    // basic decodes
    do_code(8'h3B, 12'h058, 1'b0);
    do_code(8'hFF, 12'h880, 1'b0);
    do_code(8'h80, 12'h000, 1'b0);
    do_code(8'hF0, 12'h000, 1'b0);
    do_code(8'h7F, 12'h780, 1'b1);
    do_code(8'h9A, 12'hFEC, 1'b0);
    do_code(8'hC3, 12'hFD0, 1'b1);
    do_code(8'h4F, 12'h0F0, 1'b0);
    do_code(8'h05, 12'h005, 1'b0);

    // stall: out_ready low while a new code waits at the input
    in_valid = 1'b1;
    in_fp    = 8'hC3;
    tick();
    in_fp = 8'h12;
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("stall_out_valid", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("stall_out_d", out_d, 12'hFD0);
      check("stall_in_ready", in_ready, 0);
      check("stall_out_valid_hold", out_valid, 1);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check("stall_dec_count", dec_count, exp_count);
    check("stall_in_ready_rise", in_ready, 1);
    tick();
    in_valid = 1'b0;
    check("stall_accept_0x12", busy, 1);
    for (int i = 0; i < 40 && !out_valid; i++) tick();
    check("stall_out_d_0x12", out_d, 12'h004);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    exp_count = exp_count + 1'b1;
    check("stall_dec_count_2", dec_count, exp_count);

    // reset while decoding 0x7F
    in_valid = 1'b1;
    in_fp    = 8'h7F;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_count = '0;
    check("abort_state", dbg_state, 0);
    check("abort_out_valid", out_valid, 0);
    check("abort_out_d", out_d, 0);
    check("abort_dec_count", dec_count, 0);
    check("abort_in_ready", in_ready, 1);
    check("abort_busy", busy, 0);
    do_code(8'h21, 12'h004, 1'b0);

    // counter wrap through all-ones back to zero
    for (int i = 0; i < 18; i++) begin
      logic [3:0] f;
      f = 4'(i);
      do_code({4'h0, f}, {8'h00, f}, 1'b1);
    end

    // a few random-F codes at E=0..7 with positive sign, expected from the value formula
    for (int i = 0; i < 4; i++) begin
      logic [3:0]  f;
      logic [2:0]  e;
      logic [11:0] v;
      f = 4'($urandom_range(0, 15));
      e = 3'($urandom_range(0, 7));
      v = 12'(int'(f) * (1 << int'(e)));
      do_code({1'b0, e, f}, v, 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miscompare);
    $finish;
  end

endmodule
